// File: rtl/ros2_sched_pkg.sv
// Shared definitions for the ros2 publish scheduler: FSM encodings,
// control byte layout and a helper that assembles the control byte.
package ros2_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_e;

  localparam int CTRL_WIDTH       = 8;
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_PATTERN_BIT = 1;

  localparam logic [15:0] TOGGLES_MAX = 16'hFFFF;

  // Build the ros2 control byte; unused upper bits are always zero.
  function automatic logic [CTRL_WIDTH-1:0] pack_ctrl(input logic pattern,
                                                       input logic enable);
    logic [CTRL_WIDTH-1:0] ctrl_v;
    ctrl_v                   = {CTRL_WIDTH{1'b0}};
    ctrl_v[CTRL_PATTERN_BIT] = pattern;
    ctrl_v[CTRL_ENABLE_BIT]  = enable;
    return ctrl_v;
  endfunction

endpackage

// File: rtl/ros2_period_timer.sv
// Period timer: counts 0..Pe-1 while running and flags the last count.
// A programmed period of 0 behaves as a period of 1 (pulse every cycle).
module ros2_period_timer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_int,
  input  logic                 rst_int,
  input  logic                 clear,
  input  logic                 run,
  input  logic [CNT_WIDTH-1:0] period,
  output logic                 tick_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] tick_r;
  logic [CNT_WIDTH-1:0] last_s;

  // Terminal count is Pe-1, with the zero-period clamp folded in.
  always_comb begin
    last_s = CNT_ZERO;
    if (period == CNT_ZERO) begin
      last_s = CNT_ZERO;
    end else begin
      last_s = period - CNT_ONE;
    end
  end

  assign tick_pulse = run && (tick_r == last_s);

  // Tick counter: cleared on request, wraps at the terminal count, else holds.
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      tick_r <= CNT_ZERO;
    end else if (clear) begin
      tick_r <= CNT_ZERO;
    end else if (run) begin
      if (tick_r == last_s) begin
        tick_r <= CNT_ZERO;
      end else begin
        tick_r <= tick_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ros2_pub_scheduler.sv
// Publish scheduler for the ros2 core: toggles the data-pattern bit every
// period while enabled, stops after a programmable toggle budget, and
// accepts start/stop commands and reconfiguration while not running.
module ros2_pub_scheduler
  import ros2_sched_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int DEFAULT_PERIOD = 100000000,
  parameter int DEFAULT_COUNT  = 20,
  parameter int RUN_ON_RESET   = 1
) (
  input  logic                  clk_int,
  input  logic                  rst_int,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [15:0]           cfg_count,
  input  logic                  cfg_valid,
  input  logic                  start,
  input  logic                  stop,
  output logic [CTRL_WIDTH-1:0] ros2_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           toggles
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [15:0]          RST_COUNT  = 16'(DEFAULT_COUNT);
  localparam logic                 RST_RUN    = (RUN_ON_RESET != 0) ? 1'b1 : 1'b0;
  localparam sched_state_e         RST_STATE  = (RUN_ON_RESET != 0) ? SCHED_RUN : SCHED_IDLE;

  sched_state_e         state_r;
  logic [CNT_WIDTH-1:0] period_r;
  logic [15:0]          count_r;
  logic [15:0]          toggles_r;
  logic                 pattern_r;
  logic                 enable_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 cfg_err_r;

  logic                 run_s;
  logic                 clear_s;
  logic                 tick_pulse_s;
  logic                 last_toggle_s;

  // Timer runs only in RUN; a stop or any non-RUN state parks it at zero
  // so the next run always begins a full period from its entry.
  always_comb begin
    run_s   = (state_r == SCHED_RUN);
    clear_s = (state_r != SCHED_RUN) || stop;
  end

  ros2_period_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk_int    (clk_int),
    .rst_int    (rst_int),
    .clear      (clear_s),
    .run        (run_s),
    .period     (period_r),
    .tick_pulse (tick_pulse_s)
  );

  // The current tick completes the budget (never in unlimited mode).
  always_comb begin
    last_toggle_s = 1'b0;
    if (count_r != 16'd0) begin
      last_toggle_s = ((toggles_r + 16'd1) == count_r);
    end else begin
      last_toggle_s = 1'b0;
    end
  end

  // Scheduler FSM with all outputs registered; stop has priority over
  // both start and the final tick.
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      state_r   <= RST_STATE;
      period_r  <= RST_PERIOD;
      count_r   <= RST_COUNT;
      toggles_r <= 16'd0;
      pattern_r <= 1'b0;
      enable_r  <= RST_RUN;
      busy_r    <= RST_RUN;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        SCHED_RUN: begin
          if (cfg_valid) begin
            cfg_err_r <= 1'b1;
          end
          if (stop) begin
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= SCHED_IDLE;
          end else if (tick_pulse_s) begin
            pattern_r <= ~pattern_r;
            if (toggles_r != TOGGLES_MAX) begin
              toggles_r <= toggles_r + 16'd1;
            end
            if (last_toggle_s) begin
              enable_r <= 1'b0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= SCHED_DONE;
            end
          end
        end
        SCHED_IDLE, SCHED_DONE: begin
          if (cfg_valid) begin
            period_r <= cfg_period;
            count_r  <= cfg_count;
          end
          if (stop) begin
            state_r <= SCHED_IDLE;
          end else if (start) begin
            toggles_r <= 16'd0;
            pattern_r <= 1'b0;
            enable_r  <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= SCHED_RUN;
          end
        end
        default: begin
          enable_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= SCHED_IDLE;
        end
      endcase
    end
  end

  assign ros2_ctrl = pack_ctrl(pattern_r, enable_r);
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;
  assign toggles   = toggles_r;

endmodule

// File: tb/tb_ros2_pub_scheduler.sv
// Testbench for ros2_pub_scheduler. Expected outputs come from a closed-form
// model of a run: after k cycles in a run with period Pe and budget C the
// toggle count is min(k/Pe, C), pattern is its parity, enable holds until
// the budget is reached, and a stop freezes everything at its cycle.
module tb_ros2_pub_scheduler;

  localparam int CW = 32;

  logic          clk_int    = 1'b0;
  logic          rst_int    = 1'b1;
  logic [CW-1:0] cfg_period = '0;
  logic [15:0]   cfg_count  = 16'd0;
  logic          cfg_valid  = 1'b0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
  logic [7:0]    ros2_ctrl;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [15:0]   toggles;

  int n_tests = 0;
  int n_fail  = 0;

  ros2_pub_scheduler #(
    .CNT_WIDTH      (CW),
    .DEFAULT_PERIOD (4),
    .DEFAULT_COUNT  (3),
    .RUN_ON_RESET   (1)
  ) dut (
    .clk_int    (clk_int),
    .rst_int    (rst_int),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .cfg_valid  (cfg_valid),
    .start      (start),
    .stop       (stop),
    .ros2_ctrl  (ros2_ctrl),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .toggles    (toggles)
  );

  always #5 clk_int = ~clk_int;

  task automatic step();
    @(posedge clk_int);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_tog(input int k, input int pe, input int c);
    int t;
    t = k / pe;
    if (c != 0 && t > c) t = c;
    if (c == 0 && t > 65535) t = 65535;
    return t;
  endfunction

  // Compare all outputs at run-relative cycle k against the model.
  task automatic check_cycle(input string tag, input int k, input int pe, input int c,
                             input int stop_at, input int cfg_at);
    bit stopped, en, dn, er, act;
    int kk, tog;
    stopped = (stop_at >= 0) && (k > stop_at);
    kk      = stopped ? stop_at : k;
    tog     = exp_tog(kk, pe, c);
    en      = !stopped && (c == 0 || tog < c);
    dn      = !stopped && (c != 0) && (k == c * pe);
    act     = (cfg_at >= 0) && !((stop_at >= 0) && (cfg_at > stop_at)) &&
              (c == 0 || cfg_at < c * pe);
    er      = act && (k == cfg_at + 1);
    check($sformatf("%s.k%0d.ctrl", tag, k), {24'd0, ros2_ctrl}, {30'd0, tog[0], en});
    check($sformatf("%s.k%0d.busy", tag, k), {31'd0, busy}, {31'd0, en});
    check($sformatf("%s.k%0d.done", tag, k), {31'd0, done}, {31'd0, dn});
    check($sformatf("%s.k%0d.err", tag, k), {31'd0, cfg_err}, {31'd0, er});
    check($sformatf("%s.k%0d.tog", tag, k), {16'd0, toggles}, tog);
  endtask

  // Start (or continue from reset) a run with period p / budget c and check
  // n cycles; optionally stop at cycle stop_at and issue cfg_valid at cfg_at.
  task automatic do_run(input string tag, input int p, input int c, input int n,
                        input int stop_at, input int cfg_at, input bit from_reset);
    int pe;
    pe = (p == 0) ? 1 : p;
    if (!from_reset) begin
      cfg_period = p;
      cfg_count  = c[15:0];
      cfg_valid  = 1'b1;
      start      = 1'b1;
      step();
      cfg_valid  = 1'b0;
      start      = 1'b0;
    end
    check_cycle(tag, 0, pe, c, stop_at, cfg_at);
    for (int k = 0; k < n; k++) begin
      if (k == cfg_at) begin
        cfg_period = $urandom_range(1, 9);
        cfg_count  = 16'($urandom_range(1, 7));
        cfg_valid  = 1'b1;
      end
      if (k == stop_at) stop = 1'b1;
      step();
      cfg_valid = 1'b0;
      stop      = 1'b0;
      check_cycle(tag, k + 1, pe, c, stop_at, cfg_at);
    end
  endtask

  initial begin
    int p, c, pe, n, stop_at, cfg_at, limit;

    // Reset state while rst_int is held
    #12;
    check("rst.ctrl", {24'd0, ros2_ctrl}, 32'h01);
    check("rst.busy", {31'd0, busy}, 32'd1);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.tog", {16'd0, toggles}, 32'd0);

    // Release: default run period 4, budget 3, toggles at cycles 4, 8, 12
    @(posedge clk_int);
    #1;
    rst_int = 1'b0;
    do_run("boot", 4, 3, 14, -1, -1, 1'b1);

    // From DONE: period 0 (acts as 1), budget 2, loaded with start
    do_run("p0", 0, 2, 5, -1, -1, 1'b0);

    // Unlimited run, period 5, with a rejected cfg_valid mid-run
    do_run("long", 5, 0, 10000, -1, 100, 1'b0);
    check("long.total", {16'd0, toggles}, 32'd2000);

    // Stop on the cycle of the final tick: stop wins
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop.busy", {31'd0, busy}, 32'd0);
    check("stop.held", {16'd0, toggles}, 32'd2000);
    do_run("stop3", 4, 3, 14, 11, -1, 1'b0);

    // Randomised runs
    for (int r = 0; r < 16; r++) begin
      p  = $urandom_range(0, 6);
      c  = $urandom_range(0, 4);
      pe = (p == 0) ? 1 : p;
      n  = pe * ((c == 0) ? 5 : c) + 3;
      stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      cfg_at  = -1;
      if ($urandom_range(0, 1) == 1) begin
        limit = (c == 0) ? n - 2 : c * pe - 1;
        if (stop_at >= 0 && stop_at < limit) limit = stop_at;
        cfg_at = $urandom_range(0, limit);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check($sformatf("rnd%0d.pre", r), {31'd0, busy}, 32'd0);
      do_run($sformatf("rnd%0d", r), p, c, n, stop_at, cfg_at, 1'b0);
    end

    // start and stop together in IDLE: stays IDLE
    stop = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss.busy", {31'd0, busy}, 32'd0);
    check("ss.en", {31'd0, ros2_ctrl[0]}, 32'd0);
    check("ss.done", {31'd0, done}, 32'd0);
    step();
    check("ss.busy2", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a run
    do_run("mid", 4, 3, 6, -1, -1, 1'b0);
    #2;
    rst_int = 1'b1;
    #1;
    check("arst.ctrl", {24'd0, ros2_ctrl}, 32'h01);
    check("arst.tog", {16'd0, toggles}, 32'd0);
    check("arst.busy", {31'd0, busy}, 32'd1);
    @(posedge clk_int);
    #1;
    rst_int = 1'b0;
    do_run("rerun", 4, 3, 14, -1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
